alu_cmd_rx: RTL and testbench

ALU_CMD_RX -- requirements
Module: alu_cmd_rx

---
 rtl/alu_cmd_pkg.sv | 19 +
 rtl/uart_rx_byte.sv | 91 +++++++++
 rtl/alu_cmd_rx.sv | 108 ++++++++++
 tb/tb_alu_cmd_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_pkg.sv
// Shared constants and state encodings for the ALU command receiver.
package alu_cmd_pkg;

  localparam logic [4:0] CMD_HDR = 5'b10100;

  typedef enum logic [1:0] {
    WAIT_HDR,
    WAIT_A,
    WAIT_B
  } asm_state_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 LSB-first UART byte receiver with input synchronizer and mid-bit sampling.
module uart_rx_byte
  import alu_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       stop_err,
  output logic       active
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_t       r_state, w_state_nxt;
  logic            r_sync1, r_sync2, r_sync3;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_valid, r_err;
  logic            w_fall, w_cnt_done, w_done_ok, w_done_err;

  // r_sync3 only remembers the previous synchronized level for edge detection.
  assign w_fall     = r_sync3 & ~r_sync2;
  assign w_cnt_done = (r_state == START) ? (r_cnt == HALF_M1) : (r_cnt == FULL_M1);

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_done_ok   = 1'b0;
    w_done_err  = 1'b0;
    case (r_state)
      IDLE:  if (w_fall) w_state_nxt = START;
      START: if (w_cnt_done) w_state_nxt = r_sync2 ? IDLE : DATA;
      DATA:  if (w_cnt_done && r_bit_idx == 3'd7) w_state_nxt = STOP;
      STOP: begin
        if (w_cnt_done) begin
          w_state_nxt = IDLE;
          w_done_ok   = r_sync2;
          w_done_err  = ~r_sync2;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else if (ena) r_state <= w_state_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_sync3   <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else if (ena) begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_valid <= w_done_ok;
      r_err   <= w_done_err;
      if (r_state == IDLE || w_cnt_done) r_cnt <= '0;
      else r_cnt <= r_cnt + 1'b1;
      if (r_state == START) r_bit_idx <= '0;
      if (r_state == DATA && w_cnt_done) begin
        r_shift   <= {r_sync2, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  assign data       = r_shift;
  assign data_valid = r_valid & ena;
  assign stop_err   = r_err & ena;
  assign active     = (r_state != IDLE);

endmodule

// File: rtl/alu_cmd_rx.sv
// Receives three-byte ALU commands (header/sel, A, B) over UART with inter-byte timeout.
module alu_cmd_rx
  import alu_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic [2:0] op_sel,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  asm_state_t r_state, w_state_nxt;
  logic [7:0] w_byte;
  logic       w_byte_valid, w_byte_err, w_rx_active;
  logic       w_timeout, w_ld_sel, w_ld_a, w_commit;
  logic [TW-1:0] r_to_cnt;
  logic [2:0] r_sel_sh;
  logic [7:0] r_a_sh;
  logic       r_cmd_valid, r_frame_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .rx         (rx),
    .data       (w_byte),
    .data_valid (w_byte_valid),
    .stop_err   (w_byte_err),
    .active     (w_rx_active)
  );

  // Idle time only accumulates between frames, so a long byte never trips the timeout.
  assign w_timeout = (r_state != WAIT_HDR) && !w_rx_active && (r_to_cnt == TW'(TO_LIMIT));

  always_comb begin
    w_state_nxt = r_state;
    w_ld_sel    = 1'b0;
    w_ld_a      = 1'b0;
    w_commit    = 1'b0;
    if (w_byte_err || w_timeout) begin
      w_state_nxt = WAIT_HDR;
    end else if (w_byte_valid) begin
      case (r_state)
        WAIT_HDR: begin
          if (w_byte[7:3] == CMD_HDR) begin
            w_ld_sel    = 1'b1;
            w_state_nxt = WAIT_A;
          end
        end
        WAIT_A: begin
          w_ld_a      = 1'b1;
          w_state_nxt = WAIT_B;
        end
        WAIT_B: begin
          w_commit    = 1'b1;
          w_state_nxt = WAIT_HDR;
        end
        default: w_state_nxt = WAIT_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= WAIT_HDR;
    else if (ena) r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt    <= '0;
      r_sel_sh    <= '0;
      r_a_sh      <= '0;
      op_sel      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (ena) begin
      if (r_state == WAIT_HDR || w_rx_active || w_timeout) r_to_cnt <= '0;
      else r_to_cnt <= r_to_cnt + 1'b1;
      r_cmd_valid <= w_commit;
      r_frame_err <= w_byte_err | w_timeout;
      if (w_ld_sel) r_sel_sh <= w_byte[2:0];
      if (w_ld_a)   r_a_sh   <= w_byte;
      if (w_commit) begin
        op_sel <= r_sel_sh;
        op_a   <= r_a_sh;
        op_b   <= w_byte;
      end
    end
  end

  assign cmd_valid = r_cmd_valid & ena;
  assign frame_err = r_frame_err & ena;
  assign busy      = (r_state == WAIT_A) || (r_state == WAIT_B);

endmodule

// File: tb/tb_alu_cmd_rx.sv
// Directed bench for alu_cmd_rx: commands, bad headers, stop errors, timeout, glitch, reset.
module tb_alu_cmd_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] op_a, op_b;
  logic [2:0] op_sel;
  logic       cmd_valid, frame_err, busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_cmd = 0;
  int n_ferr = 0;
  logic busy_at_cmd = 1'b1;

  alu_cmd_rx #(.CLKS_PER_BIT(4), .TIMEOUT_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .rx        (rx),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sel    (op_sel),
    .cmd_valid (cmd_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts high cycles of each pulse output, sampled mid-period.
  always @(negedge clk) begin
    if (cmd_valid) begin
      n_cmd++;
      busy_at_cmd = busy;
    end
    if (frame_err) n_ferr++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(4);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(4);
    end
    rx = stop;
    idle(4);
    rx = 1'b1;
    idle(4);
  endtask

  task automatic expect_ops(input string name, input logic [2:0] sel,
                            input logic [7:0] a, input logic [7:0] b);
    n_checks++;
    if (op_sel !== sel) begin
      n_errors++;
      $display("FAIL %s_op_sel: got %0h expected %0h", name, op_sel, sel);
    end
    n_checks++;
    if (op_a !== a) begin
      n_errors++;
      $display("FAIL %s_op_a: got %0h expected %0h", name, op_a, a);
    end
    n_checks++;
    if (op_b !== b) begin
      n_errors++;
      $display("FAIL %s_op_b: got %0h expected %0h", name, op_b, b);
    end
  endtask

  task automatic expect_counts(input string name, input int got_cmd, input int exp_cmd,
                               input int got_ferr, input int exp_ferr);
    n_checks++;
    if (got_cmd != exp_cmd) begin
      n_errors++;
      $display("FAIL %s_cmd_valid_count: got %0d expected %0d", name, got_cmd, exp_cmd);
    end
    n_checks++;
    if (got_ferr != exp_ferr) begin
      n_errors++;
      $display("FAIL %s_frame_err_count: got %0d expected %0d", name, got_ferr, exp_ferr);
    end
  endtask

  task automatic expect_busy(input string name, input logic exp);
    n_checks++;
    if (busy !== exp) begin
      n_errors++;
      $display("FAIL %s_busy: got %b expected %b", name, busy, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    expect_ops("reset", 3'd0, 8'h00, 8'h00);
    n_checks++;
    if (cmd_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_pulses: got cmd_valid=%b frame_err=%b expected 0 0", cmd_valid, frame_err);
    end
    expect_busy("reset", 1'b0);
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    int c0 = n_cmd, f0 = n_ferr;
    send_byte(8'hA3, 1'b1);
    expect_busy("basic_after_hdr", 1'b1);
    send_byte(8'h5C, 1'b1);
    expect_ops("basic_before_b", 3'd0, 8'h00, 8'h00);
    send_byte(8'h07, 1'b1);
    idle(8);
    expect_counts("basic", n_cmd - c0, 1, n_ferr - f0, 0);
    expect_ops("basic", 3'd3, 8'h5C, 8'h07);
    n_checks++;
    if (busy_at_cmd !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_busy_with_pulse: got %b expected 0", busy_at_cmd);
    end
  endtask

  task automatic test_ena_freeze();
    int c0 = n_cmd, f0 = n_ferr;
    ena = 1'b0;
    send_byte(8'hA6, 1'b1);
    send_byte(8'h99, 1'b1);
    send_byte(8'h88, 1'b1);
    ena = 1'b1;
    idle(8);
    expect_counts("ena_off", n_cmd - c0, 0, n_ferr - f0, 0);
    expect_busy("ena_off", 1'b0);
    expect_ops("ena_off", 3'd3, 8'h5C, 8'h07);
  endtask

  task automatic test_bad_header();
    int c0 = n_cmd, f0 = n_ferr;
    send_byte(8'h13, 1'b1);
    idle(4);
    expect_busy("bad_hdr", 1'b0);
    expect_counts("bad_hdr_dropped", n_cmd - c0, 0, n_ferr - f0, 0);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h1F, 1'b1);
    idle(8);
    expect_counts("bad_hdr_then_cmd", n_cmd - c0, 1, n_ferr - f0, 0);
    expect_ops("bad_hdr_then_cmd", 3'd1, 8'hFF, 8'h1F);
  endtask

  task automatic test_stop_error();
    int c0 = n_cmd, f0 = n_ferr;
    send_byte(8'hA2, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b0);
    idle(8);
    expect_counts("stop_err", n_cmd - c0, 0, n_ferr - f0, 1);
    expect_ops("stop_err_hold", 3'd1, 8'hFF, 8'h1F);
    expect_busy("stop_err", 1'b0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    idle(8);
    expect_counts("after_stop_err", n_cmd - c0, 1, n_ferr - f0, 1);
    expect_ops("after_stop_err", 3'd5, 8'h33, 8'h44);
  endtask

  task automatic test_timeout();
    int c0 = n_cmd, f0 = n_ferr;
    send_byte(8'hA4, 1'b1);
    send_byte(8'h11, 1'b1);
    expect_busy("timeout_pending", 1'b1);
    idle(17 * 4);
    expect_counts("timeout", n_cmd - c0, 0, n_ferr - f0, 1);
    expect_busy("timeout", 1'b0);
    send_byte(8'h22, 1'b1);
    idle(8);
    expect_busy("late_byte_dropped", 1'b0);
    expect_counts("late_byte_dropped", n_cmd - c0, 0, n_ferr - f0, 1);
    expect_ops("timeout_hold", 3'd5, 8'h33, 8'h44);
  endtask

  task automatic test_glitch();
    int c0 = n_cmd, f0 = n_ferr;
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(60);
    expect_counts("glitch", n_cmd - c0, 0, n_ferr - f0, 0);
    expect_busy("glitch", 1'b0);
  endtask

  task automatic test_reset_mid_cmd();
    int c0, f0;
    send_byte(8'hA6, 1'b1);
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(4);
    rx = 1'b0;
    idle(6);
    rst_n = 1'b0;
    rx = 1'b1;
    idle(3);
    expect_ops("mid_reset", 3'd0, 8'h00, 8'h00);
    expect_busy("mid_reset", 1'b0);
    rst_n = 1'b1;
    c0 = n_cmd;
    f0 = n_ferr;
    idle(60);
    expect_counts("after_reset_quiet", n_cmd - c0, 0, n_ferr - f0, 0);
    send_byte(8'hA7, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(8);
    expect_counts("after_reset_cmd", n_cmd - c0, 1, n_ferr - f0, 0);
    expect_ops("after_reset_cmd", 3'd7, 8'h01, 8'h02);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ena_freeze();
    test_bad_header();
    test_stop_error();
    test_timeout();
    test_glitch();
    test_reset_mid_cmd();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
